// File: rtl/jk_state_monitor.sv
// Observer for the two-flop JK state machine: counts state changes, detects the
// 00->11->01->10 cycle and flags a state held for DWELL_MAX unchanged samples.
module jk_state_monitor #(
   parameter int CNT_W     = 8,
   parameter int DWELL_MAX = 15
) (
   input  logic             clk,
   input  logic             res,
   input  logic             A,
   input  logic             B,
   input  logic             en,
   input  logic             clr,
   output logic [1:0]       prev_state,
   output logic [CNT_W-1:0] trans_cnt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             seq_hit,
   output logic             stuck
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEEN_00 = 2'd1,
      SEEN_11 = 2'd2,
      SEEN_01 = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_MAX);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                input logic [CNT_W-1:0] lim);
      sat_inc = (val >= lim) ? lim : val + 1'b1;
   endfunction

   state_e           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [CNT_W-1:0] trans_q, trans_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             valid_q, valid_d;
   logic             seq_hit_q, seq_hit_d;
   logic             stuck_q, stuck_d;
   logic [1:0]       s;

   assign s = {A, B};

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      trans_d   = trans_q;
      hit_d     = hit_q;
      dwell_d   = dwell_q;
      valid_d   = valid_q;
      stuck_d   = stuck_q;
      seq_hit_d = 1'b0;

      if (clr) begin
         state_d = IDLE;
         prev_d  = 2'b00;
         trans_d = '0;
         hit_d   = '0;
         dwell_d = '0;
         valid_d = 1'b0;
         stuck_d = 1'b0;
      end else if (en) begin
         if (!valid_q) begin
            // First sample after reset/clear only seeds the history.
            prev_d  = s;
            valid_d = 1'b1;
            dwell_d = '0;
            state_d = (s == 2'b00) ? SEEN_00 : IDLE;
         end else if (s != prev_q) begin
            trans_d = sat_inc(trans_q, CNT_MAX);
            dwell_d = '0;
            prev_d  = s;
            if (s == 2'b00) begin
               state_d = SEEN_00;
            end else begin
               state_d = IDLE;
               case (state_q)
                  SEEN_00: if (s == 2'b11) state_d = SEEN_11;
                  SEEN_11: if (s == 2'b01) state_d = SEEN_01;
                  SEEN_01: begin
                     if (s == 2'b10) begin
                        seq_hit_d = 1'b1;
                        hit_d     = sat_inc(hit_q, CNT_MAX);
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
         end else begin
            dwell_d = sat_inc(dwell_q, DWELL_LIM);
         end
         stuck_d = (dwell_d == DWELL_LIM);
      end
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state_q   <= IDLE;
         prev_q    <= 2'b00;
         trans_q   <= '0;
         hit_q     <= '0;
         dwell_q   <= '0;
         valid_q   <= 1'b0;
         seq_hit_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         trans_q   <= trans_d;
         hit_q     <= hit_d;
         dwell_q   <= dwell_d;
         valid_q   <= valid_d;
         seq_hit_q <= seq_hit_d;
         stuck_q   <= stuck_d;
      end
   end

   assign prev_state = prev_q;
   assign trans_cnt  = trans_q;
   assign hit_cnt    = hit_q;
   assign seq_hit    = seq_hit_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_jk_state_monitor.sv
// Bench for jk_state_monitor: two parameterisations driven in parallel, checked
// against a run-history model (list of entered states, run lengths, hit count).
module tb_jk_state_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic res, a, b, en, clr;

   logic [1:0] prev_a, prev_b;
   logic [7:0] trans_a, hit_a;
   logic [1:0] trans_b, hit_b;
   logic       seq_hit_a, seq_hit_b, stuck_a, stuck_b;

   localparam int DM_A = 4;
   localparam int DM_B = 3;

   jk_state_monitor #(.CNT_W(8), .DWELL_MAX(DM_A)) u_a (
      .clk(clk), .res(res), .A(a), .B(b), .en(en), .clr(clr),
      .prev_state(prev_a), .trans_cnt(trans_a), .hit_cnt(hit_a),
      .seq_hit(seq_hit_a), .stuck(stuck_a));

   jk_state_monitor #(.CNT_W(2), .DWELL_MAX(DM_B)) u_b (
      .clk(clk), .res(res), .A(a), .B(b), .en(en), .clr(clr),
      .prev_state(prev_b), .trans_cnt(trans_b), .hit_cnt(hit_b),
      .seq_hit(seq_hit_b), .stuck(stuck_b));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: unbounded counts of runs/hits and the current run length.
   logic [1:0] hist[$];
   int runs    = 0;
   int hits    = 0;
   int run_len = 0;
   bit pulse   = 0;

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic model_update(input logic r, input logic c, input logic e, input logic [1:0] s);
      pulse = 0;
      if (!r || c) begin
         hist.delete();
         runs = 0; hits = 0; run_len = 0;
      end else if (e) begin
         if (hist.size() == 0 || hist[hist.size()-1] != s) begin
            hist.push_back(s);
            runs++;
            run_len = 1;
            if (hist.size() >= 4) begin
               int n = hist.size();
               if (hist[n-4] == 2'b00 && hist[n-3] == 2'b11 &&
                   hist[n-2] == 2'b01 && hist[n-1] == 2'b10) begin
                  hits++;
                  pulse = 1;
               end
            end
            if (hist.size() > 4) void'(hist.pop_front());
         end else begin
            run_len++;
         end
      end
   endtask

   task automatic check_all();
      int tr, dw;
      logic [1:0] ep;
      tr = (runs > 0) ? runs - 1 : 0;
      dw = (run_len > 0) ? run_len - 1 : 0;
      ep = (hist.size() > 0) ? hist[hist.size()-1] : 2'b00;
      check("a_prev",  32'(prev_a),    32'(ep));
      check("a_trans", 32'(trans_a),   32'(sat(tr, 255)));
      check("a_hit",   32'(hit_a),     32'(sat(hits, 255)));
      check("a_pulse", 32'(seq_hit_a), 32'(pulse));
      check("a_stuck", 32'(stuck_a),   32'(dw >= DM_A));
      check("b_prev",  32'(prev_b),    32'(ep));
      check("b_trans", 32'(trans_b),   32'(sat(tr, 3)));
      check("b_hit",   32'(hit_b),     32'(sat(hits, 3)));
      check("b_pulse", 32'(seq_hit_b), 32'(pulse));
      check("b_stuck", 32'(stuck_b),   32'(dw >= DM_B));
   endtask

   task automatic step(input logic r, input logic c, input logic e, input logic [1:0] s);
      res = r; clr = c; en = e; {a, b} = s;
      @(posedge clk);
      model_update(r, c, e, s);
      #1;
      check_all();
   endtask

   task automatic run(input logic [1:0] s, input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, s);
   endtask

   task automatic full_cycle(input int n);
      run(2'b00, n); run(2'b11, n); run(2'b01, n); run(2'b10, n);
   endtask

   initial begin
      res = 1'b0; clr = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 2'($urandom));
      check("rst_trans", 32'(trans_a), 0);
      check("rst_prev",  32'(prev_a),  0);

      full_cycle(2);
      check("full_trans", 32'(trans_a), 3);
      check("full_hit",   32'(hit_a),   1);
      full_cycle(2);
      check("full2_trans", 32'(trans_a), 7);
      check("full2_hit",   32'(hit_a),   2);

      step(1'b1, 1'b1, 1'b1, 2'b00);
      run(2'b00, 1); run(2'b11, 1); run(2'b10, 1); run(2'b01, 1);
      check("broken_hit",   32'(hit_a),   0);
      check("broken_trans", 32'(trans_a), 3);
      run(2'b00, 1); run(2'b11, 1); run(2'b01, 2); run(2'b10, 1);
      check("repeat_hit", 32'(hit_a), 1);

      run(2'b11, 6);
      check("dwell_stuck", 32'(stuck_a), 1);
      run(2'b01, 1);
      check("dwell_clear", 32'(stuck_a), 0);

      step(1'b1, 1'b1, 1'b1, 2'b00);
      for (int i = 0; i < 7; i++) run((i % 2) ? 2'b11 : 2'b00, 1);
      check("sat_trans", 32'(trans_b), 3);
      for (int i = 0; i < 4; i++) full_cycle(1);
      check("sat_hit", 32'(hit_b), 3);

      step(1'b1, 1'b1, 1'b1, 2'b00);
      run(2'b00, 1); run(2'b11, 1);
      step(1'b1, 1'b0, 1'b0, 2'b01);
      step(1'b1, 1'b0, 1'b0, 2'b10);
      step(1'b1, 1'b0, 1'b0, 2'b00);
      run(2'b01, 1); run(2'b10, 1);
      check("en_resume_hit", 32'(hit_a), 1);

      run(2'b00, 1); run(2'b11, 1); run(2'b01, 1);
      step(1'b1, 1'b1, 1'b1, 2'b01);
      run(2'b10, 1);
      check("clr_nohit",   32'(hit_a),   0);
      check("clr_trans",   32'(trans_a), 0);
      check("clr_pulse",   32'(seq_hit_a), 0);

      for (int i = 0; i < 800; i++) begin
         logic [1:0] s;
         logic [1:0] pat [4];
         pat[0] = 2'b00; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b10;
         s = ($urandom_range(0, 9) < 6) ? pat[(i / 2) % 4] : 2'($urandom);
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 7) != 0), s);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
